// File: rtl/writeback_stage.sv
// writeback_stage: last stage of the MIPS pipeline.
// It accepts one retiring instruction per cycle from the memory stage and
// chooses between the ALU result and the load data. Load data is aligned
// using big-endian byte lanes and then sign- or zero-extended. The stage
// registers the result and drives the register file write port for exactly
// one cycle per retired instruction.
// Optional feature: define WB_RETIRE_COUNT_EN to add the retire_count port
// and its wrapping 32-bit counter.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  output logic [ADDR_W-1:0] reg_write,
  output logic              regwrite_con,
  output logic [DATA_W-1:0] write_data,
  output logic              wb_valid,
  output logic              misalign_err
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  logic [1:0]        offset;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic [DATA_W-1:0] load_ext;
  logic              load_bad;
  logic              misalign;
  logic [DATA_W-1:0] result;
  logic              write_en;
  logic              retire;

  // The stage is a single register, so whether it can accept depends on the hazard unit alone
  assign in_ready = !stall;

  // A flush on the accepting edge turns the instruction into a bubble
  assign retire = in_valid && in_ready && !flush;

  // Pick the addressed lanes, extend them, and flag bad alignment or a reserved size
  always_comb begin
    offset   = in_alu_result[1:0];
    half_sel = offset[1] ? in_mem_data[15:0] : in_mem_data[31:16];
    byte_sel = 8'h00;
    load_ext = in_mem_data;
    load_bad = 1'b0;
    case (offset)
      2'd0:    byte_sel = in_mem_data[31:24];
      2'd1:    byte_sel = in_mem_data[23:16];
      2'd2:    byte_sel = in_mem_data[15:8];
      default: byte_sel = in_mem_data[7:0];
    endcase
    case (in_load_size)
      SIZE_WORD: begin
        load_ext = in_mem_data;
        load_bad = (offset != 2'b00);
      end
      SIZE_HALF: begin
        load_ext = in_load_unsigned ? {{(DATA_W-16){1'b0}}, half_sel}
                                    : {{(DATA_W-16){half_sel[15]}}, half_sel};
        load_bad = offset[0];
      end
      SIZE_BYTE: begin
        load_ext = in_load_unsigned ? {{(DATA_W-8){1'b0}}, byte_sel}
                                    : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        load_bad = 1'b0;
      end
      default: begin
        load_ext = in_mem_data;
        load_bad = 1'b1;
      end
    endcase
  end

  // A faulting load retires with its raw word for debug, and register writes are suppressed
  always_comb begin
    misalign = in_memtoreg && load_bad;
    if (!in_memtoreg)
      result = in_alu_result;
    else if (misalign)
      result = in_mem_data;
    else
      result = load_ext;
    write_en = in_regwrite && (in_dest != '0) && !misalign;
  end

  // Output register: load on a retire; otherwise drop to a bubble that keeps the last index and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write    <= '0;
      regwrite_con <= 1'b0;
      write_data   <= '0;
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else if (retire) begin
      reg_write    <= in_dest;
      regwrite_con <= write_en;
      write_data   <= result;
      wb_valid     <= 1'b1;
      misalign_err <= misalign;
    end else begin
      regwrite_con <= 1'b0;
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count_q;

  // Count on the same edge that raises wb_valid, so the count already includes the visible retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_count_q <= 32'd0;
    else if (retire)
      retire_count_q <= retire_count_q + 32'd1;
  end

  assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed, self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic [4:0]  in_dest;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;
  logic [4:0]  reg_write;
  logic        regwrite_con;
  logic [31:0] write_data;
  logic        wb_valid;
  logic        misalign_err;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .stall            (stall),
    .flush            (flush),
    .in_dest          (in_dest),
    .in_regwrite      (in_regwrite),
    .in_memtoreg      (in_memtoreg),
    .in_alu_result    (in_alu_result),
    .in_mem_data      (in_mem_data),
    .in_load_size     (in_load_size),
    .in_load_unsigned (in_load_unsigned),
    .reg_write        (reg_write),
    .regwrite_con     (regwrite_con),
    .write_data       (write_data),
    .wb_valid         (wb_valid),
    .misalign_err     (misalign_err)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .retire_count     (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] rw, input logic we,
                         input logic [31:0] wd, input logic v, input logic me);
    chk({tag, ".reg_write"},    {27'b0, reg_write},    {27'b0, rw});
    chk({tag, ".regwrite_con"}, {31'b0, regwrite_con}, {31'b0, we});
    chk({tag, ".write_data"},   write_data,            wd);
    chk({tag, ".wb_valid"},     {31'b0, wb_valid},     {31'b0, v});
    chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, me});
  endtask

  task automatic drive(input logic [4:0] d, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [1:0] sz, input logic uns);
    in_valid         = 1'b1;
    in_dest          = d;
    in_regwrite      = rw;
    in_memtoreg      = m2r;
    in_alu_result    = alu;
    in_load_size     = sz;
    in_load_unsigned = uns;
  endtask

  logic [1:0]  ld_size [5];
  logic        ld_uns  [5];
  logic [31:0] ld_addr [5];
  logic [31:0] ld_exp  [5];

  initial begin
    ld_size[0] = 2'b10; ld_uns[0] = 1'b0; ld_addr[0] = 32'h0000_1001; ld_exp[0] = 32'hFFFF_FFFF;
    ld_size[1] = 2'b10; ld_uns[1] = 1'b1; ld_addr[1] = 32'h0000_1002; ld_exp[1] = 32'h0000_007F;
    ld_size[2] = 2'b01; ld_uns[2] = 1'b0; ld_addr[2] = 32'h0000_1000; ld_exp[2] = 32'hFFFF_80FF;
    ld_size[3] = 2'b01; ld_uns[3] = 1'b1; ld_addr[3] = 32'h0000_1002; ld_exp[3] = 32'h0000_7F01;
    ld_size[4] = 2'b00; ld_uns[4] = 1'b0; ld_addr[4] = 32'h0000_1000; ld_exp[4] = 32'h80FF_7F01;

    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    in_dest = 5'd0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
    in_alu_result = 32'h0; in_mem_data = 32'h80FF_7F01;
    in_load_size = 2'b00; in_load_unsigned = 1'b0;
    #1;
    chk_out("reset", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU writeback followed by a bubble that holds index and data
    drive(5'd5, 1'b1, 1'b0, 32'h1234_5678, 2'b00, 1'b0);
    step();
    chk_out("alu", 5'd5, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk_out("alu_bubble", 5'd5, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

    // Aligned loads of 0x80FF7F01, back to back
    for (int i = 0; i < 5; i++) begin
      drive(5'd3, 1'b1, 1'b1, ld_addr[i], ld_size[i], ld_uns[i]);
      step();
      chk_out($sformatf("load%0d", i), 5'd3, 1'b1, ld_exp[i], 1'b1, 1'b0);
    end

    // Misaligned word, misaligned half, and a reserved size
    drive(5'd8, 1'b1, 1'b1, 32'h0000_2002, 2'b00, 1'b0);
    step();
    chk_out("mis_word", 5'd8, 1'b0, 32'h80FF_7F01, 1'b1, 1'b1);
    drive(5'd9, 1'b1, 1'b1, 32'h0000_2001, 2'b01, 1'b1);
    step();
    chk_out("mis_half", 5'd9, 1'b0, 32'h80FF_7F01, 1'b1, 1'b1);
    drive(5'd10, 1'b1, 1'b1, 32'h0000_2000, 2'b11, 1'b0);
    step();
    chk_out("rsv_size", 5'd10, 1'b0, 32'h80FF_7F01, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    chk_out("mis_bubble", 5'd10, 1'b0, 32'h80FF_7F01, 1'b0, 1'b0);

    // Writes to $zero retire without enabling the register file
    drive(5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0);
    step();
    chk_out("zero_dest", 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // regwrite=0 instruction retires without a write
    drive(5'd7, 1'b0, 1'b0, 32'h0000_00AA, 2'b00, 1'b0);
    step();
    chk_out("no_regwrite", 5'd7, 1'b0, 32'h0000_00AA, 1'b1, 1'b0);

    // Stall: one in-flight retire, then bubbles with no repeated write
    drive(5'd12, 1'b1, 1'b0, 32'h0000_0C0C, 2'b00, 1'b0);
    step();
    chk_out("pre_stall", 5'd12, 1'b1, 32'h0000_0C0C, 1'b1, 1'b0);
    drive(5'd13, 1'b1, 1'b0, 32'h0000_0D0D, 2'b00, 1'b0);
    stall = 1'b1;
    #1;
    chk("stall.in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("stall%0d", i), 5'd12, 1'b0, 32'h0000_0C0C, 1'b0, 1'b0);
      chk($sformatf("stall%0d.in_ready", i), {31'b0, in_ready}, 32'd0);
    end
    stall = 1'b0;
    #1;
    chk("unstall.in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk_out("post_stall", 5'd13, 1'b1, 32'h0000_0D0D, 1'b1, 1'b0);

    // Flush on an accepting edge drops the instruction
    drive(5'd14, 1'b1, 1'b0, 32'h0000_0E0E, 2'b00, 1'b0);
    flush = 1'b1;
    step();
    chk_out("flush", 5'd13, 1'b0, 32'h0000_0D0D, 1'b0, 1'b0);

    // Flush together with stall: nothing accepted, bubble
    stall = 1'b1;
    step();
    chk_out("flush_stall", 5'd13, 1'b0, 32'h0000_0D0D, 1'b0, 1'b0);
    stall = 1'b0; flush = 1'b0;

    // Mid-stream reset clears outputs before the next edge
    drive(5'd15, 1'b1, 1'b0, 32'h0000_0F0F, 2'b00, 1'b0);
    step();
    chk_out("pre_reset", 5'd15, 1'b1, 32'h0000_0F0F, 1'b1, 1'b0);
    drive(5'd16, 1'b1, 1'b0, 32'h0000_1010, 2'b00, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    chk_out("first_after_reset", 5'd16, 1'b1, 32'h0000_1010, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();

`ifdef WB_RETIRE_COUNT_EN
    rst_n = 1'b0;
    #1;
    chk("cnt.reset", retire_count, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(5'd1, 1'b1, 1'b0, 32'(i), 2'b00, 1'b0);
      flush = (i == 4);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("cnt.nine", retire_count, 32'd9);
    force dut.retire_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_count_q;
    drive(5'd2, 1'b1, 1'b1, 32'h0000_0001, 2'b00, 1'b0);
    step();
    chk("cnt.misalign_retire", retire_count, 32'hFFFF_FFFF);
    drive(5'd2, 1'b1, 1'b0, 32'h0000_0001, 2'b00, 1'b0);
    step();
    chk("cnt.wrap", retire_count, 32'd0);
    in_valid = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the MIPS pipeline: accepts retiring instructions from the memory stage through a valid/ready handshake. Selects the ALU result or the load data, then aligns and extends the load data. Registers the result and drives the register file write port (`reg_write`, `regwrite_con`, `write_data`) for exactly one cycle per retired instruction. It is the writer side of the register file interface.

## Interface
Parameters:
- `DATA_W`, 32, datapath width. Only 32 is supported.
- `ADDR_W`, 5, register index width.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  memory stage presents an instruction
- `in_ready`  out  1  stage can accept; equals `!stall`
- `stall`  in  1  hazard unit holds the stage
- `flush`  in  1  discards the instruction being accepted this cycle
- `in_dest`  in  5  destination register
- `in_regwrite`  in  1  instruction writes a register
- `in_memtoreg`  in  1  1 selects load data, 0 selects ALU result
- `in_alu_result`  in  32  ALU result; also the effective address for loads
- `in_mem_data`  in  32  raw aligned word from data memory
- `in_load_size`  in  2  00 word, 01 half, 10 byte, 11 reserved
- `in_load_unsigned`  in  1  zero-extend instead of sign-extend
- `reg_write`  out  5  register file write index
- `regwrite_con`  out  1  register file write enable
- `write_data`  out  32  register file write data
- `wb_valid`  out  1  an instruction retired this cycle
- `misalign_err`  out  1  one-cycle pulse for a misaligned or reserved-size load
- `retire_count`  out  32  retired instruction count; present only with `WB_RETIRE_COUNT_EN`

## Operation
- Accept condition: `in_valid && in_ready` at a rising edge.
- Flush handling: if `flush` is also high on the accepting edge, the instruction is dropped. The drop behaves as a bubble.
- Bubble cycle: `wb_valid=0`, `regwrite_con=0`, and `reg_write`/`write_data` hold their previous values.
- Retire: an accepted, unflushed instruction produces `wb_valid=1` for one cycle.
- Write enable: `regwrite_con = in_regwrite && in_dest!=0 && !misalign`. Writes to `$zero` are never asserted.
- Result select:
  - `in_memtoreg=0`: `write_data = in_alu_result`.
  - `in_memtoreg=1`: load path with offset `a = in_alu_result[1:0]`. Byte lanes are big-endian, so byte offset 0 is bits 31:24.
- Load path by size:
  - Word: `write_data = in_mem_data`; requires `a==00`.
  - Half: `a[1]=0` selects bits 31:16, `a[1]=1` selects bits 15:0; requires `a[0]==0`.
  - Byte: offset `a` selects bits `[31-8a:24-8a]`; any `a` is valid.
  - Extension: sign-extend the selected field to 32 bits; zero-extend when `in_load_unsigned=1`.
- Misaligned or reserved-size load:
  - `misalign_err=1` and `wb_valid=1` for one cycle.
  - `regwrite_con=0`.
  - `write_data` = unaligned raw word, for debug only.
- `stall` held high:
  - `in_ready=0` and no new acceptance.
  - Outputs go to the bubble state after the in-flight instruction retires. A retired instruction is never written twice.
- The stage is a single register with no internal buffering beyond it.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on the outputs after edge N and is written by the register file at edge N+1.
- Throughput: 1 instruction per cycle while `stall=0`.
- `in_ready` is combinational from `stall` only. It has no dependency on `in_valid`.
- All outputs are registered.
- Reset values: `reg_write=0`, `regwrite_con=0`, `write_data=0`, `wb_valid=0`, `misalign_err=0`, `retire_count=0`.
- Reset asserted mid-operation: the in-flight instruction is lost and all outputs clear immediately, asynchronously.
- After `rst_n` rises, the first acceptance can occur at the next edge.
- Simultaneous `flush` and `stall`: nothing is accepted, and the output register goes to bubble.

## Configuration
- `WB_RETIRE_COUNT_EN` defined:
  - `retire_count` increments by 1 on every cycle with `wb_valid=1`, including misaligned retires.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- `WB_RETIRE_COUNT_EN` undefined:
  - The port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- ALU writeback: `in_dest=5`, `in_regwrite=1`, `in_memtoreg=0`, `in_alu_result=0x1234_5678`. Next cycle: `reg_write=5`, `regwrite_con=1`, `write_data=0x12345678`, `wb_valid=1`. The following bubble cycle has `regwrite_con=0`.
- Loads of `in_mem_data=0x80FF_7F01`:
  - Byte at `a=1`, signed: `write_data=0xFFFFFFFF`.
  - Byte at `a=2`, unsigned: `0x0000007F`.
  - Half at `a=0`, signed: `0xFFFF80FF`.
  - Half at `a=2`, unsigned: `0x00007F01`.
  - Word at `a=0`: `0x80FF7F01`.
- Misaligned word (`a=2`, `in_regwrite=1`, `in_dest=8`): `misalign_err=1`, `wb_valid=1`, `regwrite_con=0`.
- `$zero` destination (`in_dest=0`, `in_regwrite=1`): `wb_valid=1`, `regwrite_con=0`.
- Handshake:
  - `stall=1` for 3 cycles with `in_valid=1`: `in_ready=0`, one retire then bubbles, no duplicate write.
  - `flush=1` on an accepting edge: no retire.
  - `rst_n` low mid-stream: all outputs 0 before the next edge.
- With `WB_RETIRE_COUNT_EN`:
  - 10 back-to-back instructions with one flushed: `retire_count=9`.
  - Counter forced near wrap (hierarchical force of `retire_count` to 0xFFFFFFFE, then 2 retires): reads 0 after the second retire.
